// File: rtl/tdm_mux16_if.sv
// Frame-load and channel-output bundle for the 16:1 time-division multiplexer.
// master drives frames and the advance enable; slave is the multiplexer itself.
interface tdm_mux16_if #(
  parameter int DATA_W = 1
);
  logic                  load_valid;
  logic                  load_ready;
  logic [16*DATA_W-1:0]  din;
  logic                  en;
  logic [DATA_W-1:0]     dout;
  logic [3:0]            sel;
  logic                  dout_valid;
  logic                  sof;
  logic                  eof;

  modport master (
    output load_valid, din, en,
    input  load_ready, dout, sel, dout_valid, sof, eof
  );

  modport slave (
    input  load_valid, din, en,
    output load_ready, dout, sel, dout_valid, sof, eof
  );
endinterface

// File: rtl/tdm_mux16.sv
// 16:1 time-division multiplexer. A frame of 16 channels is accepted over a
// valid/ready handshake and played out one channel at a time, each held for
// HOLD_CYCLES enabled cycles, with the channel index on sel for a downstream
// 1:16 demux. A one-entry pending buffer lets frames run back to back.
// HOLD_CYCLES must be at least 1.
module tdm_mux16 #(
  parameter int DATA_W      = 1,
  parameter int HOLD_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  tdm_mux16_if.slave   bus
);

  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  typedef logic [15:0][DATA_W-1:0] frame_t;

  state_e          state_q, state_d;
  frame_t          frame_q, frame_d;
  frame_t          pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [3:0]      sel_q, sel_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic            xfer;
  logic            last_hold;
  logic            end_of_frame;

  // Ready depends only on the pending slot, never on load_valid.
  assign bus.load_ready = !pend_full_q;
  assign xfer           = bus.load_valid && !pend_full_q;
  assign last_hold      = (hold_q == HOLD_LAST);
  assign end_of_frame   = (state_q == SEND) && (sel_q == 4'd15) && last_hold;

  // Output view is decoded straight from the registers, so reset clears it at once.
  assign bus.dout_valid = (state_q == SEND);
  assign bus.dout       = (state_q == SEND) ? frame_q[sel_q] : '0;
  assign bus.sel        = sel_q;
  assign bus.sof        = (state_q == SEND) && (sel_q == 4'd0) && (hold_q == '0);
  assign bus.eof        = end_of_frame;

  // Next-state: frame load, channel/hold stepping, pending buffer and end-of-frame reload.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a value unassigned (no latches).
    state_d     = state_q;
    frame_d     = frame_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    sel_d       = sel_q;
    hold_d      = hold_q;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SEND;
          frame_d = bus.din;
          sel_d   = 4'd0;
          hold_d  = '0;
        end
      end

      SEND: begin
        if (bus.en && end_of_frame) begin
          // Wrap: pending frame first, then a same-cycle bypass load, else go idle.
          sel_d  = 4'd0;
          hold_d = '0;
          if (pend_full_q) begin
            frame_d     = pend_q;
            pend_full_d = 1'b0;
          end else if (xfer) begin
            frame_d = bus.din;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (bus.en) begin
            if (last_hold) begin
              hold_d = '0;
              sel_d  = sel_q + 4'd1;
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end
          if (xfer) begin
            pend_d      = bus.din;
            pend_full_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous reset that aborts any frame and drops the pending one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      // NOTE: the frame and pending buffers are reset too; dout must read 0 and
      // nothing stale may be replayed after a reset, so they are not left undefined.
      frame_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      sel_q       <= 4'd0;
      hold_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      frame_q     <= frame_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      sel_q       <= sel_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux16.sv
// Self-checking bench for tdm_mux16: two instances (1-bit/hold 1 and 4-bit/hold 3)
// compared every cycle against a frame-position reference model.
module tb_tdm_mux16;

  localparam int DW_A = 1;
  localparam int H_A  = 1;
  localparam int DW_B = 4;
  localparam int H_B  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_mux16_if #(.DATA_W(DW_A)) a_if ();
  tdm_mux16_if #(.DATA_W(DW_B)) b_if ();

  tdm_mux16 #(.DATA_W(DW_A), .HOLD_CYCLES(H_A)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  tdm_mux16 #(.DATA_W(DW_B), .HOLD_CYCLES(H_B)) u_b (.clk(clk), .rst(rst), .bus(b_if));

  logic        lv_a, en_a, lv_b, en_b;
  logic [15:0] din_a;
  logic [63:0] din_b;

  assign a_if.load_valid = lv_a;
  assign a_if.din        = din_a;
  assign a_if.en         = en_a;
  assign b_if.load_valid = lv_b;
  assign b_if.din        = din_b;
  assign b_if.en         = en_b;

  // Reference model: a frame is a position 0..16*H-1 counted in enabled cycles.
  typedef struct {
    bit          active;
    int          pos;
    logic [63:0] frame;
    bit          pend_full;
    logic [63:0] pend;
  } model_t;

  model_t ma, mb;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.active    = 1'b0;
    m.pos       = 0;
    m.frame     = '0;
    m.pend_full = 1'b0;
    m.pend      = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic lv, logic [63:0] din, logic en, int h);
    model_t n    = m;
    bit     xfer = lv && !m.pend_full;
    if (!m.active) begin
      if (xfer) begin
        n.active = 1'b1;
        n.frame  = din;
        n.pos    = 0;
      end
    end else if (en && m.pos == 16*h - 1) begin
      n.pos = 0;
      if (m.pend_full) begin
        n.frame     = m.pend;
        n.pend_full = 1'b0;
      end else if (xfer) begin
        n.frame = din;
      end else begin
        n.active = 1'b0;
      end
    end else begin
      if (en) n.pos = m.pos + 1;
      if (xfer) begin
        n.pend      = din;
        n.pend_full = 1'b1;
      end
    end
    return n;
  endfunction

  // Packs {load_ready, dout_valid, sof, eof, sel, dout} the model predicts.
  function automatic logic [63:0] model_out(model_t m, int dw, int h);
    logic [63:0] sel;
    logic [63:0] dout;
    logic        sof, eof;
    sel  = m.active ? 64'(m.pos / h) : 64'd0;
    dout = m.active ? ((m.frame >> (sel * dw)) & ((64'd1 << dw) - 64'd1)) : 64'd0;
    sof  = m.active && (m.pos == 0);
    eof  = m.active && (m.pos == 16*h - 1);
    return {40'b0, !m.pend_full, m.active, sof, eof, sel[3:0], dout[15:0]};
  endfunction

  function automatic logic [63:0] obs_a();
    return {40'b0, a_if.load_ready, a_if.dout_valid, a_if.sof, a_if.eof, a_if.sel, 16'(a_if.dout)};
  endfunction

  function automatic logic [63:0] obs_b();
    return {40'b0, b_if.load_ready, b_if.dout_valid, b_if.sof, b_if.eof, b_if.sel, 16'(b_if.dout)};
  endfunction

  // One clock: models advance on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    ma = model_step(ma, lv_a, 64'(din_a), en_a, H_A);
    mb = model_step(mb, lv_b, din_b, en_b, H_B);
    @(negedge clk);
    check("a_out", obs_a(), model_out(ma, DW_A, H_A));
    check("b_out", obs_b(), model_out(mb, DW_B, H_B));
  endtask

  initial begin
    rst   = 1'b1;
    lv_a  = 1'b0; en_a = 1'b1; din_a = '0;
    lv_b  = 1'b0; en_b = 1'b1; din_b = '0;
    ma    = model_reset();
    mb    = model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_a", obs_a(), model_out(ma, DW_A, H_A));
    check("rst_b", obs_b(), model_out(mb, DW_B, H_B));
    rst = 1'b0;
    repeat (2) tick();

    // Single frame 16'hA5C3, hold 1.
    lv_a = 1'b1; din_a = 16'hA5C3;
    tick();
    lv_a = 1'b0;
    check("a5c3_sof", 64'(a_if.sof), 64'd1);
    check("a5c3_bit0", 64'(a_if.dout), 64'd1);
    repeat (17) tick();

    // Back to back through the pending buffer.
    lv_a = 1'b1; din_a = 16'hFFFF;
    tick();
    lv_a = 1'b0;
    repeat (3) tick();
    check("b2b_sel3", 64'(a_if.sel), 64'd3);
    lv_a = 1'b1; din_a = 16'h0000;
    tick();
    lv_a = 1'b0;
    check("b2b_not_ready", 64'(a_if.load_ready), 64'd0);
    repeat (30) tick();

    // Bypass load exactly on the eof cycle.
    lv_a = 1'b1; din_a = 16'h8001;
    tick();
    lv_a = 1'b0;
    repeat (15) tick();
    check("byp_eof", 64'(a_if.eof), 64'd1);
    lv_a = 1'b1; din_a = 16'h8001;
    tick();
    lv_a = 1'b0;
    check("byp_sof", {a_if.sof, a_if.sel, a_if.dout}, {1'b1, 4'd0, 1'b1});
    repeat (18) tick();

    // Stall with hold 3 and channel k = k.
    lv_b = 1'b1; din_b = 64'hFEDC_BA98_7654_3210;
    tick();
    lv_b = 1'b0;
    repeat (13) tick();
    en_b = 1'b0;
    repeat (5) tick();
    check("stall_sel", {b_if.sel, b_if.dout}, {4'd4, 4'd4});
    en_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (b_if.dout_valid) check("chan_eq_sel", 64'(b_if.dout), 64'(i / 3 + 4 < 16 ? (i + 14) / 3 : 0));
    end

    // Asynchronous reset mid-frame with sel=7 and a pending frame.
    lv_a = 1'b1; din_a = 16'h1234;
    tick();
    lv_a = 1'b0;
    repeat (3) tick();
    lv_a = 1'b1; din_a = 16'hBEEF;
    tick();
    lv_a = 1'b0;
    repeat (3) tick();
    check("pre_rst_sel7", {a_if.sel, a_if.load_ready}, {4'd7, 1'b0});
    #2 rst = 1'b1;
    #1;
    ma = model_reset();
    mb = model_reset();
    check("rst_mid_a", obs_a(), model_out(ma, DW_A, H_A));
    check("rst_mid_b", obs_b(), model_out(mb, DW_B, H_B));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_ready", 64'(a_if.load_ready), 64'd1);
    lv_a = 1'b1; din_a = 16'h0001;
    tick();
    lv_a = 1'b0;
    check("rst_restart", {a_if.sof, a_if.sel}, {1'b1, 4'd0});
    repeat (20) tick();

    // Randomized traffic: sparse loads, then dense loads, random enable.
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500) begin
        lv_a = ($urandom_range(0, 15) == 0);
        lv_b = ($urandom_range(0, 31) == 0);
      end else begin
        lv_a = $urandom_range(0, 1) == 1;
        lv_b = $urandom_range(0, 1) == 1;
      end
      en_a  = ($urandom_range(0, 3) != 0);
      en_b  = ($urandom_range(0, 3) != 0);
      din_a = 16'($urandom);
      din_b = {$urandom, $urandom};
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux16.md
Name: tdm_mux16

Overview:
- Time-division 16:1 multiplexer: the transmit end of the 16-channel select/demux path.
- Accepts a 16-channel frame over a valid/ready handshake and presents channel 0..15 one at a time on a single output.
- Drives the matching 4-bit channel select alongside the data, so a downstream 1:16 demux can redistribute it.
- One-entry pending buffer allows back-to-back frames with no idle gap.

Parameters:
- DATA_W, 1: width of each channel's data.
- HOLD_CYCLES, 1: clock cycles each channel is held on the output (must be >= 1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- load_valid  in  1  frame offered on din
- load_ready  out  1  block can accept a frame this cycle
- din  in  16*DATA_W  frame; channel k occupies bits [k*DATA_W +: DATA_W]
- en  in  1  advance enable; 0 freezes channel and hold counters
- dout  out  DATA_W  current channel data; 0 when dout_valid=0
- sel  out  4  current channel index
- dout_valid  out  1  dout/sel carry a live channel
- sof  out  1  first hold cycle of channel 0
- eof  out  1  last hold cycle of channel 15

Behaviour:
- Reset (async, immediate, any state):
  - state IDLE; frame, pending buffer, sel and hold_cnt all 0; pend_full=0.
  - dout=0, dout_valid=0, sof=0, eof=0; load_ready=1 once rst is released.
  - A frame in progress is aborted and any pending frame is discarded.
- States: IDLE and SEND.
- Handshake:
  - A transfer occurs on a rising edge where load_valid=1 and load_ready=1.
  - load_ready = !pend_full, combinational, independent of load_valid.
  - din is sampled only on a transfer.
- IDLE:
  - On a transfer, din goes into the frame register, sel=0, hold_cnt=0, state becomes SEND.
  - dout_valid=1 and sof=1 from the next cycle, giving one-cycle latency.
- SEND:
  - dout = frame[sel]; dout_valid=1.
  - hold_cnt counts 0..HOLD_CYCLES-1 on cycles with en=1.
  - On a cycle with en=1 and hold_cnt=HOLD_CYCLES-1: hold_cnt returns to 0 and sel increments.
  - en=0 holds sel, hold_cnt, dout and sof/eof unchanged; dout_valid stays 1.
  - sof = (sel==0 && hold_cnt==0). eof = (sel==15 && hold_cnt==HOLD_CYCLES-1).
  - A transfer during SEND writes din to the pending buffer and sets pend_full.
  - The current frame is not disturbed.
- End of frame (eof=1 and en=1):
  - If pend_full: frame takes the pending buffer, pend_full clears, sel wraps to 0, state stays SEND. No gap cycle.
  - Else, if a transfer occurs in this same cycle: din loads directly into the frame (bypass), sel=0, state stays SEND. No gap cycle.
  - Else: state returns to IDLE, and dout_valid, sof and sel go to 0 on the next cycle.
- Same-edge events: when end of frame and a transfer coincide while pend_full=1, no transfer can occur because load_ready=0. Only the pending-buffer reload happens.
- sel wraps 15 -> 0 only via the end-of-frame rules above; sel never exceeds 15.
- HOLD_CYCLES=1: sel advances on every enabled cycle, and sof and eof are single-cycle pulses.

Test Plan:
- Reset mid-frame: assert rst with sel=7 and pend_full=1 -> same cycle dout=0, dout_valid=0, sel=0; after release load_ready=1; state IDLE, so the next transfer starts at sel=0.
- Single frame, DATA_W=1, HOLD_CYCLES=1: transfer din=16'hA5C3 -> next cycle sof=1, then dout follows bits 0..15 (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1) with sel 0..15; eof on sel=15; dout_valid drops the cycle after.
- Back-to-back via pending buffer: transfer 16'hFFFF, then 16'h0000 at sel=3 -> load_ready=0 until the wrap; sel 15 -> 0 with no gap; second frame outputs all zeros; load_ready returns to 1 on the wrap.
- Bypass at end of frame: pend empty; transfer 16'h8001 exactly on the eof cycle -> sel wraps to 0 with no gap, dout=1 at sel=0 and sel=15, 0 otherwise.
- Stall with HOLD_CYCLES=3: hold en=0 for 5 cycles at sel=4, hold_cnt=1 -> sel, dout and hold_cnt frozen; resume -> sel=4 lasts exactly 3 enabled cycles total; frame length = 48 enabled cycles.
- DATA_W=4: din channel k = k -> dout equals sel on every valid cycle, 0 through 15.
